// File: rtl/data_stack.sv
// Forth-style data stack: TOS/NOS in registers, deeper cells in a register file.
// Illegal operations are dropped and latch a sticky overflow/underflow flag.
module data_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                         c_CLOCK,
    input  logic                         c_RESET,
    input  logic [2:0]                   f_stackop,
    input  logic [WIDTH-1:0]             i_DATA,
    output logic [WIDTH-1:0]             o_TOS,
    output logic [WIDTH-1:0]             o_NOS,
    output logic [$clog2(DEPTH+1)-1:0]   o_DEPTH,
    output logic                         o_OVERFLOW,
    output logic                         o_UNDERFLOW
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int MD = DEPTH - 2;
    localparam int AW = (MD > 1) ? $clog2(MD) : 1;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_PUSH   = 3'b001,
        OP_DROP   = 3'b010,
        OP_DUP    = 3'b011,
        OP_SWAP   = 3'b100,
        OP_OVER   = 3'b101,
        OP_UNARY  = 3'b110,
        OP_BINARY = 3'b111
    } op_e;

    op_e op;
    assign op = op_e'(f_stackop);

    logic [WIDTH-1:0] tos_q, nos_q, tos_d, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, unf_q, ovf_set, unf_set;
    logic [WIDTH-1:0] mem_q [MD];
    logic [AW-1:0]    push_idx, pop_idx;
    logic             mem_we;

    logic has1, has2, has3, full;
    logic need1, need2, grow, shrink, swap, unary;
    logic [WIDTH-1:0] val;

    assign has1 = (depth_q != '0);
    assign has2 = (depth_q >= DW'(2));
    assign has3 = (depth_q >= DW'(3));
    assign full = (depth_q == DW'(DEPTH));

    // Cell k of the stack (k < n-2) lives at mem_q[k]
    assign push_idx = AW'(depth_q - DW'(2));
    assign pop_idx  = AW'(depth_q - DW'(3));

    always_comb begin
        need1  = 1'b0;
        need2  = 1'b0;
        grow   = 1'b0;
        shrink = 1'b0;
        swap   = 1'b0;
        unary  = 1'b0;
        val    = i_DATA;
        case (op)
            OP_PUSH:   grow = 1'b1;
            OP_DROP:   begin need1 = 1'b1; shrink = 1'b1; val = nos_q; end
            OP_DUP:    begin need1 = 1'b1; grow = 1'b1; val = tos_q; end
            OP_SWAP:   begin need2 = 1'b1; swap = 1'b1; end
            OP_OVER:   begin need2 = 1'b1; grow = 1'b1; val = nos_q; end
            OP_UNARY:  begin need1 = 1'b1; unary = 1'b1; end
            OP_BINARY: begin need2 = 1'b1; shrink = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        tos_d   = tos_q;
        nos_d   = nos_q;
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        mem_we  = 1'b0;
        if ((need1 && !has1) || (need2 && !has2)) begin
            unf_set = 1'b1;
        end else if (grow && full) begin
            ovf_set = 1'b1;
        end else if (grow) begin
            mem_we  = has2;
            tos_d   = val;
            nos_d   = tos_q;
            depth_d = depth_q + 1'b1;
        end else if (shrink) begin
            tos_d   = val;
            nos_d   = has3 ? mem_q[pop_idx] : '0;
            depth_d = depth_q - 1'b1;
        end else if (swap) begin
            tos_d = nos_q;
            nos_d = tos_q;
        end else if (unary) begin
            tos_d = i_DATA;
        end
    end

    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_q | ovf_set;
            unf_q   <= unf_q | unf_set;
        end
    end

    // Deep storage is unreadable until refilled, so it carries no reset
    always_ff @(posedge c_CLOCK) begin
        if (mem_we) mem_q[push_idx] <= nos_q;
    end

    assign o_TOS       = tos_q;
    assign o_NOS       = nos_q;
    assign o_DEPTH     = depth_q;
    assign o_OVERFLOW  = ovf_q;
    assign o_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: directed scenarios plus random ops
// against a queue-based stack model.
module tb_data_stack;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] SWAP = 3'd4, OVER = 3'd5, UNARY = 3'd6, BINARY = 3'd7;

    logic             c_CLOCK = 1'b0;
    logic             c_RESET = 1'b0;
    logic [2:0]       f_stackop = NOP;
    logic [WIDTH-1:0] i_DATA = '0;
    logic [WIDTH-1:0] o_TOS, o_NOS;
    logic [DW-1:0]    o_DEPTH;
    logic             o_OVERFLOW, o_UNDERFLOW;

    data_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .c_CLOCK    (c_CLOCK),
        .c_RESET    (c_RESET),
        .f_stackop  (f_stackop),
        .i_DATA     (i_DATA),
        .o_TOS      (o_TOS),
        .o_NOS      (o_NOS),
        .o_DEPTH    (o_DEPTH),
        .o_OVERFLOW (o_OVERFLOW),
        .o_UNDERFLOW(o_UNDERFLOW)
    );

    always #5 c_CLOCK = ~c_CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d);
        int n;
        logic [WIDTH-1:0] t;
        n = stk.size();
        case (op)
            PUSH:   if (n == DEPTH) m_ovf = 1'b1; else stk.push_back(d);
            DROP:   if (n < 1) m_unf = 1'b1; else void'(stk.pop_back());
            DUP:    if (n < 1) m_unf = 1'b1;
                    else if (n == DEPTH) m_ovf = 1'b1;
                    else stk.push_back(stk[n-1]);
            SWAP:   if (n < 2) m_unf = 1'b1;
                    else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
            OVER:   if (n < 2) m_unf = 1'b1;
                    else if (n == DEPTH) m_ovf = 1'b1;
                    else stk.push_back(stk[n-2]);
            UNARY:  if (n < 1) m_unf = 1'b1; else stk[n-1] = d;
            BINARY: if (n < 2) m_unf = 1'b1;
                    else begin void'(stk.pop_back()); stk[n-2] = d; end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        int n;
        logic [WIDTH-1:0] et, en;
        n  = stk.size();
        et = (n >= 1) ? stk[n-1] : '0;
        en = (n >= 2) ? stk[n-2] : '0;
        check({tag, ".tos"}, 32'(o_TOS), 32'(et));
        check({tag, ".nos"}, 32'(o_NOS), 32'(en));
        check({tag, ".depth"}, 32'(o_DEPTH), 32'(n));
        check({tag, ".ovf"}, 32'(o_OVERFLOW), 32'(m_ovf));
        check({tag, ".unf"}, 32'(o_UNDERFLOW), 32'(m_unf));
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] d);
        @(negedge c_CLOCK);
        f_stackop = op;
        i_DATA    = d;
        @(posedge c_CLOCK);
        #1;
        model_apply(op, d);
        check_model(tag);
    endtask

    // Reset asserted between edges; outputs must clear before any edge
    task automatic async_reset(input string tag);
        @(negedge c_CLOCK);
        f_stackop = NOP;
        #2;
        c_RESET = 1'b1;
        #1;
        check({tag, ".rst_tos"}, 32'(o_TOS), 32'd0);
        check({tag, ".rst_nos"}, 32'(o_NOS), 32'd0);
        check({tag, ".rst_depth"}, 32'(o_DEPTH), 32'd0);
        check({tag, ".rst_flags"}, {30'd0, o_OVERFLOW, o_UNDERFLOW}, 32'd0);
        #1;
        c_RESET = 1'b0;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        async_reset("init");

        // push then binary arithmetic
        do_op("s28", PUSH, 16'd5);
        do_op("s28", PUSH, 16'd3);
        do_op("s28", BINARY, 16'd8);
        check("s28.tos8", 32'(o_TOS), 32'd8);
        check("s28.dep1", 32'(o_DEPTH), 32'd1);

        // shuffles
        async_reset("s29");
        do_op("s29", PUSH, 16'd1);
        do_op("s29", PUSH, 16'd2);
        do_op("s29", SWAP, 16'd0);
        check("s29.swap", {16'(o_TOS), 16'(o_NOS)}, {16'd1, 16'd2});
        do_op("s29", OVER, 16'd0);
        check("s29.over", {16'(o_TOS), 16'(o_NOS)}, {16'd2, 16'd1});
        do_op("s29", DUP, 16'd0);
        check("s29.dup", 32'(o_DEPTH), 32'd4);

        // full condition
        async_reset("s30");
        for (int i = 1; i <= DEPTH; i++) do_op("s30.fill", PUSH, 16'(i));
        do_op("s30.over", PUSH, 16'd99);
        check("s30.ovf", 32'(o_OVERFLOW), 32'd1);
        check("s30.tos16", 32'(o_TOS), 32'd16);
        for (int i = 0; i < DEPTH; i++) do_op("s30.drain", DROP, 16'd0);
        check("s30.empty", 32'(o_DEPTH), 32'd0);

        // empty / underflow
        async_reset("s31");
        do_op("s31.drop", DROP, 16'd0);
        check("s31.unf", 32'(o_UNDERFLOW), 32'd1);
        do_op("s31.push", PUSH, 16'd7);
        do_op("s31.bin", BINARY, 16'd1);
        check("s31.tos7", 32'(o_TOS), 32'd7);

        // async reset mid-sequence
        do_op("s32", PUSH, 16'd4);
        do_op("s32", PUSH, 16'd9);
        async_reset("s32");
        do_op("s32.after", PUSH, 16'd2);
        check("s32.tos2", 32'(o_TOS), 32'd2);

        // unary and refill wrap-around
        async_reset("s33");
        do_op("s33", PUSH, 16'hFFFF);
        do_op("s33", UNARY, 16'h0001);
        check("s33.unary", 32'(o_TOS), 32'h1);
        for (int r = 0; r < 3; r++) begin
            while (stk.size() < DEPTH)
                do_op("s33.fill", PUSH, 16'($urandom));
            while (stk.size() > 0)
                do_op("s33.drain", DROP, 16'd0);
        end

        // random: alternate growth-biased and shrink-biased phases
        async_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            if (i % 400 == 399) async_reset("rnd");
            op = 3'($urandom_range(0, 7));
            if ((i / 100) % 2 == 1 && op inside {PUSH, DUP, OVER} && $urandom_range(0, 1) == 1)
                op = DROP;
            do_op("rnd", op, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
